if_id_buffer: RTL
=================

# if_id_buffer

Two-entry elastic pipeline buffer between instruction fetch and decode in the RV64 core. It captures the PC/instruction pair produced by fetch, holds it across decode stalls without dropping or duplicating instructions, and discards in-flight entries on a redirect flush. It also tags misaligned fetch addresses and counts decode-starvation bubbles for performance debug.

## Interface

Parameters:
- `NOP_INST`, default 32'h00000013: instruction driven on `inst_o` when no valid entry is present (`addi x0,x0,0`).
- `ADDR_W`, default 64: PC width.

Ports:
- `clk`  input  1  core clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `inst_addr_i`  input  ADDR_W  PC from instruction fetch.
- `inst_i`  input  32  instruction word from instruction fetch.
- `in_valid_i`  input  1  fetch presents a valid pair this cycle.
- `in_ready_o`  output  1  buffer can accept a pair this cycle.
- `flush_i`  input  1  redirect from EX (jump/branch taken); kill all held entries.
- `inst_addr_o`  output  ADDR_W  PC of head entry to decode.
- `inst_o`  output  32  instruction of head entry to decode.
- `misalign_o`  output  1  head entry's PC had `[1:0] != 0`.
- `out_valid_o`  output  1  head entry valid.
- `out_ready_i`  input  1  decode consumes head this cycle.
- `bubble_cnt_o`  output  32  saturating count of cycles with `out_ready_i=1` and `out_valid_o=0`.

## Operation

- Storage: 2 slots, each holding {PC, inst, misalign}. Read pointer (1 bit), write pointer (1 bit), occupancy `count` in 0..2.
- Push: `in_valid_i & in_ready_o & !flush_i` writes slot[wptr], sets misalign = `|inst_addr_i[1:0]`, increments wptr.
- Pop: `out_valid_o & out_ready_i & !flush_i` advances rptr.
- `count` next: +1 on push only, −1 on pop only, unchanged on both or neither.
- `in_ready_o = (count != 2)`; depends only on registered state, with no combinational path from `out_ready_i` or `in_valid_i`.
- `out_valid_o = (count != 0)`.
- Outputs are driven from slot[rptr] when `count != 0`. Otherwise `inst_o = NOP_INST`, `inst_addr_o = 0`, `misalign_o = 0`.
- Flush: next state `count = 0`, `rptr = wptr = 0`. A push or pop requested in the flush cycle is ignored. Slot contents need not be cleared.
- Bubble counter: increments when `out_ready_i & !out_valid_o`, saturates at 32'hFFFFFFFF, and is not cleared by flush.
- Pointers wrap modulo 2. Slot order is strictly FIFO.

## Timing

- Reset (async assert, sync-safe release): `count=0`, pointers 0, `bubble_cnt_o=0`.
- Reset output values: `out_valid_o=0`, `in_ready_o=1`, `inst_o=NOP_INST`, `inst_addr_o=0`, `misalign_o=0`.
- Latency: a pair pushed at edge N appears on outputs after edge N (`out_valid_o=1` in cycle N+1) when the buffer was empty. No same-cycle bypass.
- Throughput: 1 pair/cycle sustained when `out_ready_i` is held high.
- Full (`count=2`): `in_ready_o=0`. Fetch must hold its pair, and no push occurs even if decode pops that cycle. `in_ready_o` returns to 1 the cycle after the pop.
- Empty with `out_ready_i=1`: no pop, bubble counted.
- Flush while full or with a simultaneous push/pop: outputs show NOP/invalid in the cycle after flush, and `in_ready_o=1`.
- Reset asserted mid-transfer: all entries are lost immediately, and outputs go to reset values asynchronously.

## Test plan

- Reset: assert `rst_n=0` mid-stream → `out_valid_o=0`, `inst_o=32'h00000013`, `in_ready_o=1`, `bubble_cnt_o=0` without a clock edge.
- Streaming: push PC 0x80000000/0x80000004/0x80000008 on consecutive cycles with `out_ready_i=1` → the same pairs appear on outputs one cycle later, in order, with `count` never exceeding 1.
- Backpressure: hold `out_ready_i=0`, push 3 pairs → the first two are accepted, `in_ready_o=0` after the second, and the third is held. Release → outputs 0x80000000, then 0x80000004, then 0x80000008, with no loss or duplication.
- Flush: with 2 entries held, assert `flush_i` together with `in_valid_i` for PC 0x8000000C → next cycle `out_valid_o=0`, `inst_o=NOP`. A push of 0x80000100 on the following cycle is the next instruction output.
- Misalign: push PC 0x80000002 → `misalign_o=1` while that entry is head. The following aligned entry shows `misalign_o=0`.
- Bubble count: 5 cycles with `out_ready_i=1` and the buffer empty → `bubble_cnt_o=5`. Cycles with `out_ready_i=0` add nothing. Preloading 32'hFFFFFFFF via force and adding one more bubble cycle leaves it at 32'hFFFFFFFF.

Source files
------------

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
// Two-entry elastic buffer between instruction fetch and decode. Holds
// PC/instruction pairs in strict FIFO order across decode stalls, drops all
// held pairs on a redirect flush, tags misaligned PCs and keeps a saturating
// count of decode-starvation bubbles.
// Handshake outputs come only from registered state, so there is no
// combinational path from out_ready_i or in_valid_i to in_ready_o.
// ---------------------------------------------------------------------------
module if_id_buffer #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [31:0]       inst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [31:0]       inst_o,
    output logic              misalign_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       bubble_cnt_o
);

    localparam logic [1:0]  CNT_EMPTY = 2'd0;
    localparam logic [1:0]  CNT_FULL  = 2'd2;
    localparam logic [31:0] BUBBLE_MAX = 32'hFFFF_FFFF;

    // A PC is misaligned when either of its two low bits is set.
    function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
        return |addr[1:0];
    endfunction

    // Slot storage
    logic [ADDR_W-1:0] slot_addr_r [2];
    logic [31:0]       slot_inst_r [2];
    logic              slot_mis_r  [2];

    // Control state
    logic        rptr_r;
    logic        wptr_r;
    logic [1:0]  count_r;
    logic [31:0] bubble_cnt_r;

    // Next-state and handshake signals
    logic        rptr_nxt_s;
    logic        wptr_nxt_s;
    logic [1:0]  count_nxt_s;
    logic [31:0] bubble_cnt_nxt_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        push_s;
    logic        pop_s;
    logic        bubble_s;

    // Handshake qualification; a flush cancels any push or pop in its cycle.
    always_comb begin
        in_ready_s  = (count_r != CNT_FULL);
        out_valid_s = (count_r != CNT_EMPTY);
        push_s      = in_valid_i & in_ready_s & ~flush_i;
        pop_s       = out_valid_s & out_ready_i & ~flush_i;
        bubble_s    = out_ready_i & ~out_valid_s;
    end

    // Pointer and occupancy next state; flush returns everything to empty.
    always_comb begin
        rptr_nxt_s  = rptr_r;
        wptr_nxt_s  = wptr_r;
        count_nxt_s = count_r;
        if (flush_i) begin
            rptr_nxt_s  = 1'b0;
            wptr_nxt_s  = 1'b0;
            count_nxt_s = CNT_EMPTY;
        end else begin
            if (push_s) begin
                wptr_nxt_s = ~wptr_r;
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (pop_s) begin
                rptr_nxt_s = ~rptr_r;
            end else begin
                rptr_nxt_s = rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + 2'd1;
                2'b01:   count_nxt_s = count_r - 2'd1;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Bubble counter next value; saturates and is unaffected by flush.
    always_comb begin
        bubble_cnt_nxt_s = bubble_cnt_r;
        if (bubble_s && (bubble_cnt_r != BUBBLE_MAX)) begin
            bubble_cnt_nxt_s = bubble_cnt_r + 32'd1;
        end else begin
            bubble_cnt_nxt_s = bubble_cnt_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r       <= 1'b0;
            wptr_r       <= 1'b0;
            count_r      <= CNT_EMPTY;
            bubble_cnt_r <= 32'd0;
        end else begin
            rptr_r       <= rptr_nxt_s;
            wptr_r       <= wptr_nxt_s;
            count_r      <= count_nxt_s;
            bubble_cnt_r <= bubble_cnt_nxt_s;
        end
    end

    // Slot write on an accepted push; contents are left as-is on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_addr_r[i] <= '0;
                slot_inst_r[i] <= 32'd0;
                slot_mis_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            slot_addr_r[wptr_r] <= inst_addr_i;
            slot_inst_r[wptr_r] <= inst_i;
            slot_mis_r[wptr_r]  <= addr_misaligned(inst_addr_i);
        end
    end

    // Head presentation: held slot when non-empty, otherwise a NOP.
    always_comb begin
        inst_addr_o = '0;
        inst_o      = NOP_INST;
        misalign_o  = 1'b0;
        if (out_valid_s) begin
            inst_addr_o = slot_addr_r[rptr_r];
            inst_o      = slot_inst_r[rptr_r];
            misalign_o  = slot_mis_r[rptr_r];
        end else begin
            inst_addr_o = '0;
            inst_o      = NOP_INST;
            misalign_o  = 1'b0;
        end
    end

    assign in_ready_o   = in_ready_s;
    assign out_valid_o  = out_valid_s;
    assign bubble_cnt_o = bubble_cnt_r;

endmodule
